irq_ctrl: RTL
=============

// Module: irq_ctrl
// PURPOSE
//  Interrupt controller behind the memory-mapped register file's IRQSTA/IRQEN/IRQDIS registers.
//  - Synchronizes and edge-detects the peripheral request lines (pushbuttons, dips, mouse, kbd, timer).
//  - Keeps the sticky pending vector and masks it.
//  - Picks the highest-priority source and sequences one request/acknowledge/end-of-interrupt handshake with the CPU at a time.
// PARAMETERS
//  NSRC         8  number of interrupt sources; bit i = source i
//  IDW          3  width of irq_id; must satisfy 2**IDW >= NSRC
//  SYNC_STAGES  2  synchronizer flops per source; legal range 2..3
// PORTS
//  clk         in   1     system clock
//  rst         in   1     asynchronous reset, active high
//  src         in   NSRC  raw level request lines, asynchronous to clk
//  en_mask     in   NSRC  per-source enable (IRQEN contents)
//  glob_dis    in   1     global disable (IRQDIS); 1 = no new requests are raised
//  clr_we      in   1     one-cycle pulse: software write to IRQSTA
//  clr_mask    in   NSRC  write data; pending <= pending & clr_mask (0 bits clear)
//  irq_ack     in   1     CPU accepts the presented interrupt (1-cycle pulse)
//  eoi         in   1     CPU finished the handler (1-cycle pulse)
//  pending     out  NSRC  sticky pending vector (IRQSTA readback)
//  irq         out  1     interrupt request to CPU
//  irq_id      out  IDW   index of the requested / in-service source
//  in_service  out  1     handler active; no further irq until eoi
// BEHAVIOUR
//  Reset (async, any state): sync chains=0, edge regs=0, pending=0, FSM=IDLE, irq=0, irq_id=0, in_service=0.
//  Input path: src -> SYNC_STAGES flops -> s; s_d = s delayed 1 cycle; rise = s & ~s_d.
//    A src level held high raises one request only. It must go low and high again to raise another.
//  Pending update per bit, each edge: set if rise; else clear if clr_we & ~clr_mask; else clear if ack-clear (below).
//    Set wins over any clear in the same cycle.
//  Request vector: req = pending & en_mask; eligible = |req & ~glob_dis.
//  Priority: fixed; lowest index wins. Indices >= NSRC never appear.
//  FSM states:
//    IDLE : irq=0, in_service=0.
//           If eligible: irq_id <= lowest set bit of req, go to REQ.
//    REQ  : irq=1, irq_id held stable (no preemption by a higher source arriving).
//           If irq_ack: pending[irq_id] cleared on this edge (unless re-set by rise the same cycle); go to INSVC.
//           Else if withdrawn (req[irq_id]==0 or glob_dis==1): go to IDLE; irq drops the next cycle.
//           irq_ack and withdrawal in the same cycle: the ack wins.
//    INSVC: irq=0, in_service=1, irq_id held.
//           If eoi: go to IDLE. A new request can be raised on the following edge.
//           Pending bits keep accumulating while in INSVC.
//  irq_ack outside REQ and eoi outside INSVC are ignored. They have no state effect.
//  Latency (SYNC_STAGES=2, E0 = first edge sampling src high, source enabled, FSM in IDLE):
//    pending bit visible after E2; irq high after E3.
//  Outputs are all registered. pending reflects writes one cycle after clr_we.
// TESTING
//  1 Reset, en_mask=8'hFF; src[2] 0->1 held high -> pending=8'h04 after E2; irq=1, irq_id=2 after E3;
//    no second request while src[2] stays high.
//  2 src[5] and src[1] rise in the same cycle -> irq_id=1; ack -> pending=8'h20, in_service=1;
//    eoi -> after 1 cycle in IDLE, irq=1, irq_id=5.
//  3 In REQ with id=3: clr_we=1, clr_mask=8'hF7 -> irq=0 the next cycle, pending=0, FSM=IDLE, no ack needed.
//  4 glob_dis=1 with pending=8'h10, en_mask=8'hFF -> irq stays 0 for 100 cycles;
//    glob_dis->0 -> irq=1, irq_id=4 one cycle later.
//  5 Same-cycle rise on src[0] and clr_we with clr_mask=8'hFE -> pending[0]=1 (set wins).
//    Same-cycle ack and re-rise of the acked source -> pending bit stays 1.
//  6 Assert rst asynchronously mid-INSVC (not at a clk edge) -> irq, in_service, pending, irq_id read 0 immediately.
//    After release, a stale eoi is ignored and a new rise is requested normally.

Source files
------------

// File: rtl/irq_ctrl.sv
// Interrupt controller: synchronizes and edge-detects request lines, keeps a sticky
// pending vector, and runs one request/ack/eoi handshake with the CPU at a time.
//
//  state | meaning
//  ------+------------------------------------------------------------
//  IDLE  | no request presented; picks the lowest eligible source
//  REQ   | irq high, irq_id frozen until ack or withdrawal
//  INSVC | handler running; no new irq until eoi
module irq_ctrl #(
  parameter int NSRC        = 8,
  parameter int IDW         = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] src,
  input  logic [NSRC-1:0] en_mask,
  input  logic            glob_dis,
  input  logic            clr_we,
  input  logic [NSRC-1:0] clr_mask,
  input  logic            irq_ack,
  input  logic            eoi,
  output logic [NSRC-1:0] pending,
  output logic            irq,
  output logic [IDW-1:0]  irq_id,
  output logic            in_service
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
    $error("irq_ctrl: SYNC_STAGES must be 2 or 3");
  end
  if ((2 ** IDW) < NSRC) begin : g_bad_idw
    $error("irq_ctrl: IDW too narrow for NSRC");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    INSVC = 2'd2
  } state_t;

  state_t          state;
  logic [NSRC-1:0] sync_q [SYNC_STAGES];
  logic [NSRC-1:0] s;
  logic [NSRC-1:0] s_d;
  logic [NSRC-1:0] rise;
  logic [NSRC-1:0] req;
  logic [NSRC-1:0] id_hit;
  logic [NSRC-1:0] clr_bits;
  logic [NSRC-1:0] ack_bits;
  logic [NSRC-1:0] pending_nxt;
  logic            eligible;
  logic            ack_clr;
  logic            withdrawn;

  function automatic logic [IDW-1:0] first_set(input logic [NSRC-1:0] v);
    logic [IDW-1:0] idx;
    idx = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (v[i]) idx = IDW'(i);
    end
    return idx;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      s_d <= '0;
    end else begin
      sync_q[0] <= src;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      s_d <= s;
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d;

  always_comb begin
    id_hit = '0;
    for (int i = 0; i < NSRC; i++) id_hit[i] = (irq_id == IDW'(i));
  end

  assign req       = pending & en_mask;
  assign eligible  = (|req) & ~glob_dis;
  assign ack_clr   = (state == REQ) & irq_ack;
  assign withdrawn = ~(|(req & id_hit)) | glob_dis;

  // A rising edge outranks both the software clear and the ack clear.
  assign clr_bits    = clr_we ? ~clr_mask : '0;
  assign ack_bits    = ack_clr ? id_hit : '0;
  assign pending_nxt = (pending & ~clr_bits & ~ack_bits) | rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= pending_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      irq        <= 1'b0;
      irq_id     <= '0;
      in_service <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (eligible) begin
            irq_id <= first_set(req);
            irq    <= 1'b1;
            state  <= REQ;
          end
        end
        REQ: begin
          if (irq_ack) begin
            irq        <= 1'b0;
            in_service <= 1'b1;
            state      <= INSVC;
          end else if (withdrawn) begin
            irq   <= 1'b0;
            state <= IDLE;
          end
        end
        INSVC: begin
          if (eoi) begin
            in_service <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          irq        <= 1'b0;
          in_service <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
